// File: rtl/whirlpool_mat_vector2rows_if.sv
// Handshake bundle for the vector-to-rows streamer: one 512-bit vector in,
// one 8-byte row (or column) out per beat.
interface whirlpool_mat_vector2rows_if;
  logic         in_valid;
  logic         in_ready;
  logic [0:511] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_idx;
  logic         out_last;
  logic [7:0]   out_b0;
  logic [7:0]   out_b1;
  logic [7:0]   out_b2;
  logic [7:0]   out_b3;
  logic [7:0]   out_b4;
  logic [7:0]   out_b5;
  logic [7:0]   out_b6;
  logic [7:0]   out_b7;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last,
    input  out_b0, out_b1, out_b2, out_b3, out_b4, out_b5, out_b6, out_b7
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last,
    output out_b0, out_b1, out_b2, out_b3, out_b4, out_b5, out_b6, out_b7
  );
endinterface

// File: rtl/whirlpool_mat_vector2rows.sv
// Unpacks a 512-bit Whirlpool state vector into eight 8-byte rows (or columns),
// one per accepted beat, with zero-bubble reload on the last beat.
module whirlpool_mat_vector2rows #(
  parameter bit TRANSPOSE = 1'b0
) (
  input logic                         clk,
  input logic                         rst,
  whirlpool_mat_vector2rows_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic [0:511] vec_q, vec_d;
  logic         last_beat;
  logic         accept;
  logic [7:0]   sel [8];

  // in_ready must not look at in_valid; accept is the qualified handshake
  assign last_beat    = (state_q == SEND) && (idx_q == 3'd7) && bus.out_ready;
  assign bus.in_ready = (state_q == IDLE) || last_beat;
  assign accept       = bus.in_ready && bus.in_valid;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    if (accept) begin
      vec_d   = bus.in_vec;
      idx_d   = '0;
      state_d = SEND;
    end else if ((state_q == SEND) && bus.out_ready) begin
      if (idx_q == 3'd7) state_d = IDLE;
      else               idx_d   = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
    end
  end

  // Byte Brc starts at bit 64r+8c, i.e. bit index {r,c,3'b000}
  if (TRANSPOSE) begin : g_col
    always_comb begin
      for (int unsigned j = 0; j < 8; j++) sel[j] = vec_q[{3'(j), idx_q, 3'd0} +: 8];
    end
  end else begin : g_row
    always_comb begin
      for (int unsigned j = 0; j < 8; j++) sel[j] = vec_q[{idx_q, 3'(j), 3'd0} +: 8];
    end
  end

  assign bus.out_valid = (state_q == SEND);
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = (idx_q == 3'd7);
  assign bus.out_b0    = sel[0];
  assign bus.out_b1    = sel[1];
  assign bus.out_b2    = sel[2];
  assign bus.out_b3    = sel[3];
  assign bus.out_b4    = sel[4];
  assign bus.out_b5    = sel[5];
  assign bus.out_b6    = sel[6];
  assign bus.out_b7    = sel[7];

endmodule

// File: tb/tb_whirlpool_mat_vector2rows.sv
// Drives row-mode and column-mode instances with identical stimulus and checks
// both against a queue of expected beats built from the matrix byte layout.
module tb_whirlpool_mat_vector2rows;

  typedef struct packed {
    logic [2:0]  idx;
    logic [63:0] r0;
    logic [63:0] r1;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [0:511] in_vec;
  logic [7:0]   vb [64];

  beat_t        q[$];
  bit           loaded;
  bit           accepted;
  int           checks = 0;
  int           errors = 0;

  whirlpool_mat_vector2rows_if bus0 ();
  whirlpool_mat_vector2rows_if bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_vec    = in_vec;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_vec    = in_vec;
  assign bus1.out_ready = out_ready;

  whirlpool_mat_vector2rows #(.TRANSPOSE(1'b0)) dut_row (.clk(clk), .rst(rst), .bus(bus0));
  whirlpool_mat_vector2rows #(.TRANSPOSE(1'b1)) dut_col (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_vec_seq(input int base);
    for (int k = 0; k < 64; k++) vb[k] = 8'(base + k);
    for (int k = 0; k < 64; k++) in_vec[8*k +: 8] = vb[k];
  endtask

  task automatic set_vec_rand();
    for (int k = 0; k < 64; k++) vb[k] = 8'($urandom);
    for (int k = 0; k < 64; k++) in_vec[8*k +: 8] = vb[k];
  endtask

  // Check outputs mid-cycle, then advance the model across the next rising edge.
  task automatic step();
    bit          exp_rdy, exp_vld;
    beat_t       b;
    logic [63:0] g0, g1;
    @(negedge clk);
    exp_vld = (q.size() != 0);
    exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
    g0 = {bus0.out_b0, bus0.out_b1, bus0.out_b2, bus0.out_b3,
          bus0.out_b4, bus0.out_b5, bus0.out_b6, bus0.out_b7};
    g1 = {bus1.out_b0, bus1.out_b1, bus1.out_b2, bus1.out_b3,
          bus1.out_b4, bus1.out_b5, bus1.out_b6, bus1.out_b7};
    check("in_ready_row", 64'(bus0.in_ready), 64'(exp_rdy));
    check("in_ready_col", 64'(bus1.in_ready), 64'(exp_rdy));
    check("out_valid_row", 64'(bus0.out_valid), 64'(exp_vld));
    check("out_valid_col", 64'(bus1.out_valid), 64'(exp_vld));
    if (exp_vld) begin
      check("out_idx_row", 64'(bus0.out_idx), 64'(q[0].idx));
      check("out_idx_col", 64'(bus1.out_idx), 64'(q[0].idx));
      check("out_last_row", 64'(bus0.out_last), 64'(q[0].idx == 3'd7));
      check("out_last_col", 64'(bus1.out_last), 64'(q[0].idx == 3'd7));
      check("bytes_row", g0, q[0].r0);
      check("bytes_col", g1, q[0].r1);
    end else if (!loaded) begin
      check("idle_idx", 64'(bus0.out_idx), 64'd0);
      check("idle_last", 64'(bus0.out_last), 64'd0);
      check("idle_bytes_row", g0, 64'd0);
      check("idle_bytes_col", g1, 64'd0);
    end
    accepted = 1'b0;
    if (rst) begin
      q.delete();
      loaded = 1'b0;
    end else begin
      if (exp_vld && out_ready) void'(q.pop_front());
      if (in_valid && exp_rdy) begin
        for (int r = 0; r < 8; r++) begin
          b.idx = 3'(r);
          for (int j = 0; j < 8; j++) begin
            b.r0[63-8*j -: 8] = vb[8*r + j];
            b.r1[63-8*j -: 8] = vb[8*j + r];
          end
          q.push_back(b);
        end
        loaded   = 1'b1;
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic present_until_accepted(input string tag);
    int n = 0;
    in_valid = 1'b1;
    do begin
      step();
      n++;
    end while (!accepted && n < 40);
    check(tag, 64'(accepted), 64'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; loaded = 1'b0;
    set_vec_seq(0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) step();

    // Sequential vector, consumer always ready, then idle.
    out_ready = 1'b1;
    set_vec_seq(8'h00);
    present_until_accepted("accept_first");
    in_valid = 1'b0;
    repeat (10) step();

    // Back-to-back: second vector is taken on the first vector's last beat.
    set_vec_seq(8'h00);
    present_until_accepted("accept_a");
    set_vec_seq(8'h40);
    present_until_accepted("accept_b");
    in_valid = 1'b0;
    repeat (10) step();

    // Backpressure 1,0,0 with in_valid held high and the offered vector changing.
    set_vec_seq(8'h80);
    in_valid = 1'b1;
    for (int c = 0; c < 45; c++) begin
      out_ready = ((c % 3) == 0);
      step();
      set_vec_rand();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) step();

    // Reset in the middle of a stream at idx 3.
    set_vec_seq(8'hA0);
    present_until_accepted("accept_pre_reset");
    in_valid = 1'b0;
    for (int n = 0; n < 20 && !(q.size() != 0 && q[0].idx == 3'd3); n++) step();
    check("reached_idx3", 64'(q.size() != 0 && q[0].idx == 3'd3), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    set_vec_seq(8'hC0);
    present_until_accepted("accept_post_reset");
    in_valid = 1'b0;
    repeat (10) step();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      set_vec_rand();
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = (($urandom % 4) != 0);
      rst       = (($urandom % 64) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
